// File: rtl/sliding_corrector_pkg.sv
// sliding_corrector_pkg: shared types and helpers for the sliding corrector.
//   decision_e : 2-bit per-position decision code from the sliding detector.
//   popcount   : number of set bits in a vector of up to POPCNT_MAX_W bits.
package sliding_corrector_pkg;

  typedef enum logic [1:0] {
    NO_FLIP   = 2'd0,
    FLIP_CUR  = 2'd1,
    FLIP_NEXT = 2'd2,
    FLIP_PAIR = 2'd3
  } decision_e;

  localparam int POPCNT_MAX_W = 256;

  function automatic logic [8:0] popcount(input logic [POPCNT_MAX_W-1:0] v);
    logic [8:0] n;
    n = '0;
    for (int i = 0; i < POPCNT_MAX_W; i++) n += 9'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/sliding_corrector_flip_mask_decoder.sv
// flip_mask_decoder: combinational decode of per-position decisions.
//   err_pos  : [width-1:0] x 2-bit decision codes, index 0 = earliest bit
//   req_mask : bits requested for flipping inside this frame (OR-merged)
//   spill    : request for bit 'width', i.e. bit 0 of the next frame
module flip_mask_decoder
  import sliding_corrector_pkg::*;
#(
  parameter int width = 16
) (
  input  logic [width-1:0][1:0] err_pos,
  output logic [width-1:0]      req_mask,
  output logic                  spill
);

  // One extra bit on top catches the FLIP_NEXT request of the last position.
  logic [width:0] ext;

  always_comb begin
    ext = '0;
    for (int i = 0; i < width; i++) begin
      case (decision_e'(err_pos[i]))
        FLIP_CUR:  ext[i] = 1'b1;
        FLIP_NEXT: ext[i+1] = 1'b1;
        FLIP_PAIR: begin
          ext[i]   = 1'b1;
          ext[i+1] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign req_mask = ext[width-1:0];
  assign spill    = ext[width];

endmodule

// File: rtl/sliding_corrector.sv
// sliding_corrector: applies detector flip decisions to the sliced bitstream.
//   clk, rst (sync, active high)
//   en           : correction enable (0 = pass-through, carry discarded)
//   in_valid     : bits_in / mmse_err_pos carry a frame this cycle
//   bits_in      : sliced bits, index 0 = earliest
//   mmse_err_pos : per-position 2-bit decision codes
//   clr_stats    : synchronous clear of the statistics counters
//   out_valid    : bits_out / flip_mask carry a frame (2 cycles after in_valid)
//   bits_out     : corrected bits, flip_mask : bits flipped in that frame
//   flip_count / frame_count : saturating statistics
// Build option: define SLIDING_CORRECTOR_STATS_EN to include the counters;
// otherwise they read 0 and clr_stats is ignored.
module sliding_corrector
  import sliding_corrector_pkg::*;
#(
  parameter int width        = 16,
  parameter int cnt_bitwidth = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    in_valid,
  input  logic [width-1:0]        bits_in,
  input  logic [width-1:0][1:0]   mmse_err_pos,
  input  logic                    clr_stats,
  output logic                    out_valid,
  output logic [width-1:0]        bits_out,
  output logic [width-1:0]        flip_mask,
  output logic [cnt_bitwidth-1:0] flip_count,
  output logic [cnt_bitwidth-1:0] frame_count
);

  localparam int STAGES = 2;

  logic [width-1:0] req_mask;
  logic             spill;

  flip_mask_decoder #(.width(width)) u_dec (
    .err_pos  (mmse_err_pos),
    .req_mask (req_mask),
    .spill    (spill)
  );

  logic [STAGES-1:0] vld_pipe_d, vld_pipe_q;
  logic [width-1:0]  s1_bits_d, s1_bits_q, s1_mask_d, s1_mask_q;
  logic              carry_d, carry_q;
  logic [width-1:0]  bits_out_d, bits_out_q, flip_mask_d, flip_mask_q;

  always_comb begin
    vld_pipe_d  = {vld_pipe_q[STAGES-2:0], in_valid};
    s1_bits_d   = s1_bits_q;
    s1_mask_d   = s1_mask_q;
    carry_d     = carry_q;
    bits_out_d  = bits_out_q;
    flip_mask_d = flip_mask_q;
    // Carry survives idle cycles; only an accepted frame consumes it.
    if (in_valid) begin
      s1_bits_d = bits_in;
      if (en) begin
        s1_mask_d = req_mask | width'(carry_q);
        carry_d   = spill;
      end else begin
        s1_mask_d = '0;
        carry_d   = 1'b0;
      end
    end
    if (vld_pipe_q[0]) begin
      bits_out_d  = s1_bits_q ^ s1_mask_q;
      flip_mask_d = s1_mask_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q  <= '0;
      s1_bits_q   <= '0;
      s1_mask_q   <= '0;
      carry_q     <= 1'b0;
      bits_out_q  <= '0;
      flip_mask_q <= '0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      s1_bits_q   <= s1_bits_d;
      s1_mask_q   <= s1_mask_d;
      carry_q     <= carry_d;
      bits_out_q  <= bits_out_d;
      flip_mask_q <= flip_mask_d;
    end
  end

  assign out_valid = vld_pipe_q[STAGES-1];
  assign bits_out  = bits_out_q;
  assign flip_mask = flip_mask_q;

`ifdef SLIDING_CORRECTOR_STATS_EN
  // Sums are one bit wider than the larger operand so overflow is visible.
  localparam int SW = ((cnt_bitwidth > 9) ? cnt_bitwidth : 9) + 1;
  localparam logic [SW-1:0] CNT_MAX = (SW'(1) << cnt_bitwidth) - SW'(1);

  logic [cnt_bitwidth-1:0] flip_cnt_d, flip_cnt_q, frame_cnt_d, frame_cnt_q;
  logic [SW-1:0]           flip_base, frame_base, flip_sum, frame_sum;

  always_comb begin
    // A clear in the same cycle as an increment leaves just that increment.
    flip_base   = clr_stats ? '0 : SW'(flip_cnt_q);
    frame_base  = clr_stats ? '0 : SW'(frame_cnt_q);
    flip_sum    = flip_base + SW'(popcount(POPCNT_MAX_W'(s1_mask_q)));
    frame_sum   = frame_base + SW'(1);
    flip_cnt_d  = cnt_bitwidth'(flip_base);
    frame_cnt_d = cnt_bitwidth'(frame_base);
    if (vld_pipe_q[0]) begin
      flip_cnt_d  = (flip_sum > CNT_MAX)  ? cnt_bitwidth'(CNT_MAX) : cnt_bitwidth'(flip_sum);
      frame_cnt_d = (frame_sum > CNT_MAX) ? cnt_bitwidth'(CNT_MAX) : cnt_bitwidth'(frame_sum);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flip_cnt_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      flip_cnt_q  <= flip_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign flip_count  = flip_cnt_q;
  assign frame_count = frame_cnt_q;
`else
  logic unused_clr_stats;
  assign unused_clr_stats = clr_stats;
  assign flip_count  = '0;
  assign frame_count = '0;
`endif

endmodule

// File: tb/tb_sliding_corrector.sv
module tb_sliding_corrector;

`ifdef SLIDING_CORRECTOR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst, en, in_valid, clr_stats;
  logic [15:0]       bits_in;
  logic [15:0][1:0]  mmse_err_pos;
  logic              out_valid, s_out_valid;
  logic [15:0]       bits_out, flip_mask, s_bits_out, s_flip_mask;
  logic [31:0]       flip_count, frame_count;
  logic [3:0]        s_flip_count, s_frame_count;

  int n_chk = 0;
  int n_fail = 0;
  int exp_flips = 0;
  int exp_frames = 0;

  always #5 clk = ~clk;

  sliding_corrector #(.width(16), .cnt_bitwidth(32)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .bits_in(bits_in),
    .mmse_err_pos(mmse_err_pos), .clr_stats(clr_stats), .out_valid(out_valid),
    .bits_out(bits_out), .flip_mask(flip_mask), .flip_count(flip_count),
    .frame_count(frame_count)
  );

  // Narrow counters so saturation is reachable in a few frames.
  sliding_corrector #(.width(16), .cnt_bitwidth(4)) dut_small (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .bits_in(bits_in),
    .mmse_err_pos(mmse_err_pos), .clr_stats(clr_stats), .out_valid(s_out_valid),
    .bits_out(s_bits_out), .flip_mask(s_flip_mask), .flip_count(s_flip_count),
    .frame_count(s_frame_count)
  );

  function automatic logic [15:0][1:0] code_at(input int pos, input logic [1:0] code);
    logic [15:0][1:0] v;
    v = '0;
    v[pos] = code;
    return v;
  endfunction

  // Present one frame for one cycle; returns 1 time unit after the accepting edge.
  task automatic put(input logic [15:0] b, input logic [15:0][1:0] c, input logic e);
    in_valid = 1'b1; bits_in = b; mmse_err_pos = c; en = e;
    @(posedge clk); #1;
    in_valid = 1'b0; bits_in = '0; mmse_err_pos = '0; en = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; clr_stats = 1'b0;
    bits_in = '0; mmse_err_pos = '0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    n_chk++; if (bits_out !== 16'h0) begin n_fail++; $display("FAIL rst_bits: got %h want 0000", bits_out); end
    n_chk++; if (flip_mask !== 16'h0) begin n_fail++; $display("FAIL rst_mask: got %h want 0000", flip_mask); end
    n_chk++; if (flip_count !== 32'd0) begin n_fail++; $display("FAIL rst_flips: got %0d want 0", flip_count); end
    n_chk++; if (frame_count !== 32'd0) begin n_fail++; $display("FAIL rst_frames: got %0d want 0", frame_count); end
    rst = 1'b0;
    exp_flips = 0; exp_frames = 0;
  endtask

  task automatic test_pass_through;
    put(16'hA5A5, '0, 1'b1);
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pt_early: got %b want 0", out_valid); end
    @(posedge clk); #1;
    exp_frames++;
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pt_valid: got %b want 1", out_valid); end
    n_chk++; if (bits_out !== 16'hA5A5) begin n_fail++; $display("FAIL pt_bits: got %h want a5a5", bits_out); end
    n_chk++; if (flip_mask !== 16'h0) begin n_fail++; $display("FAIL pt_mask: got %h want 0000", flip_mask); end
    n_chk++; if (flip_count !== 32'd0) begin n_fail++; $display("FAIL pt_flips: got %0d want 0", flip_count); end
    n_chk++; if (frame_count !== (STATS ? exp_frames : 0)) begin n_fail++; $display("FAIL pt_frames: got %0d want %0d", frame_count, STATS ? exp_frames : 0); end
    @(posedge clk); #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pt_drop: got %b want 0", out_valid); end
    n_chk++; if (bits_out !== 16'hA5A5) begin n_fail++; $display("FAIL pt_hold: got %h want a5a5", bits_out); end
  endtask

  task automatic test_decode;
    logic [15:0][1:0] dc [3];
    logic [15:0]      dm [3];
    int               dp [3];
    dc[0] = code_at(3, 2'd1);                     dm[0] = 16'h0008; dp[0] = 1;
    dc[1] = code_at(3, 2'd3);                     dm[1] = 16'h0018; dp[1] = 2;
    dc[2] = code_at(3, 2'd2) | code_at(4, 2'd1);  dm[2] = 16'h0010; dp[2] = 1;
    for (int k = 0; k < 3; k++) begin
      put(16'hFFFF, dc[k], 1'b1);
      @(posedge clk); #1;
      exp_frames++; exp_flips += dp[k];
      n_chk++; if (flip_mask !== dm[k]) begin n_fail++; $display("FAIL dec%0d_mask: got %h want %h", k, flip_mask, dm[k]); end
      n_chk++; if (bits_out !== ~dm[k]) begin n_fail++; $display("FAIL dec%0d_bits: got %h want %h", k, bits_out, ~dm[k]); end
      n_chk++; if (flip_count !== (STATS ? exp_flips : 0)) begin n_fail++; $display("FAIL dec%0d_flips: got %0d want %0d", k, flip_count, STATS ? exp_flips : 0); end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0]      fb [3];
    logic [15:0][1:0] fc [3];
    logic [15:0]      fo [3];
    logic [15:0]      fm [3];
    int               fp [3];
    fb[0] = 16'h1111; fc[0] = code_at(0, 2'd1);  fm[0] = 16'h0001; fo[0] = 16'h1110; fp[0] = 1;
    fb[1] = 16'h00F0; fc[1] = code_at(7, 2'd3);  fm[1] = 16'h0180; fo[1] = 16'h0170; fp[1] = 2;
    fb[2] = 16'hC000; fc[2] = code_at(15, 2'd1); fm[2] = 16'h8000; fo[2] = 16'h4000; fp[2] = 1;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        in_valid = 1'b1; bits_in = fb[k]; mmse_err_pos = fc[k]; en = 1'b1;
      end else begin
        in_valid = 1'b0; bits_in = '0; mmse_err_pos = '0;
      end
      @(posedge clk); #1;
      if (k >= 1) begin
        exp_frames++; exp_flips += fp[k-1];
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b%0d_valid: got %b want 1", k-1, out_valid); end
        n_chk++; if (bits_out !== fo[k-1]) begin n_fail++; $display("FAIL b2b%0d_bits: got %h want %h", k-1, bits_out, fo[k-1]); end
        n_chk++; if (flip_mask !== fm[k-1]) begin n_fail++; $display("FAIL b2b%0d_mask: got %h want %h", k-1, flip_mask, fm[k-1]); end
        n_chk++; if (frame_count !== (STATS ? exp_frames : 0)) begin n_fail++; $display("FAIL b2b%0d_frames: got %0d want %0d", k-1, frame_count, STATS ? exp_frames : 0); end
      end
    end
  endtask

  task automatic test_spill;
    put(16'h0000, code_at(15, 2'd2), 1'b1);
    @(posedge clk); #1;
    exp_frames++;
    n_chk++; if (bits_out !== 16'h0000) begin n_fail++; $display("FAIL spill_first: got %h want 0000", bits_out); end
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL spill_idle: got %b want 0", out_valid); end
    put(16'h0000, '0, 1'b1);
    @(posedge clk); #1;
    exp_frames++; exp_flips += 1;
    n_chk++; if (bits_out !== 16'h0001) begin n_fail++; $display("FAIL spill_bits: got %h want 0001", bits_out); end
    n_chk++; if (flip_mask !== 16'h0001) begin n_fail++; $display("FAIL spill_mask: got %h want 0001", flip_mask); end
    // Carry and an own request for bit 0 must merge as OR, not cancel.
    put(16'h0000, code_at(15, 2'd2), 1'b1);
    put(16'h0000, code_at(0, 2'd1), 1'b1);
    n_chk++; if (flip_mask !== 16'h0000) begin n_fail++; $display("FAIL spill_or_first: got %h want 0000", flip_mask); end
    @(posedge clk); #1;
    exp_frames += 2; exp_flips += 1;
    n_chk++; if (flip_mask !== 16'h0001) begin n_fail++; $display("FAIL spill_or_mask: got %h want 0001", flip_mask); end
    n_chk++; if (flip_count !== (STATS ? exp_flips : 0)) begin n_fail++; $display("FAIL spill_flips: got %0d want %0d", flip_count, STATS ? exp_flips : 0); end
  endtask

  task automatic test_en0;
    put(16'h1234, code_at(15, 2'd3), 1'b0);
    @(posedge clk); #1;
    exp_frames++;
    n_chk++; if (flip_mask !== 16'h0000) begin n_fail++; $display("FAIL en0_mask: got %h want 0000", flip_mask); end
    n_chk++; if (bits_out !== 16'h1234) begin n_fail++; $display("FAIL en0_bits: got %h want 1234", bits_out); end
    put(16'h0000, '0, 1'b1);
    @(posedge clk); #1;
    exp_frames++;
    n_chk++; if (flip_mask !== 16'h0000) begin n_fail++; $display("FAIL en0_carry: got %h want 0000", flip_mask); end
    n_chk++; if (flip_count !== (STATS ? exp_flips : 0)) begin n_fail++; $display("FAIL en0_flips: got %0d want %0d", flip_count, STATS ? exp_flips : 0); end
  endtask

  task automatic test_reset_mid;
    put(16'h0000, code_at(15, 2'd2), 1'b1);
    put(16'h00FF, code_at(15, 2'd2), 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_flips = 0; exp_frames = 0;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid: got %b want 0", out_valid); end
    n_chk++; if (bits_out !== 16'h0000) begin n_fail++; $display("FAIL rm_bits: got %h want 0000", bits_out); end
    n_chk++; if (frame_count !== 32'd0) begin n_fail++; $display("FAIL rm_frames: got %0d want 0", frame_count); end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_ghost%0d: got %b want 0", k, out_valid); end
    end
    put(16'h0000, '0, 1'b1);
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_early: got %b want 0", out_valid); end
    @(posedge clk); #1;
    exp_frames++;
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rm_after: got %b want 1", out_valid); end
    n_chk++; if (bits_out !== 16'h0000) begin n_fail++; $display("FAIL rm_carry: got %h want 0000", bits_out); end
    n_chk++; if (frame_count !== (STATS ? exp_frames : 0)) begin n_fail++; $display("FAIL rm_count: got %0d want %0d", frame_count, STATS ? exp_frames : 0); end
  endtask

  task automatic test_stats;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 10; k++) put(16'h0000, code_at(5, 2'd3), 1'b1);
    @(posedge clk); #1;
    n_chk++; if (flip_count !== (STATS ? 32'd20 : 32'd0)) begin n_fail++; $display("FAIL st_flips10: got %0d want %0d", flip_count, STATS ? 20 : 0); end
    n_chk++; if (frame_count !== (STATS ? 32'd10 : 32'd0)) begin n_fail++; $display("FAIL st_frames10: got %0d want %0d", frame_count, STATS ? 10 : 0); end
    n_chk++; if (s_flip_count !== (STATS ? 4'd15 : 4'd0)) begin n_fail++; $display("FAIL st_flipsat: got %0d want %0d", s_flip_count, STATS ? 15 : 0); end
    n_chk++; if (s_frame_count !== (STATS ? 4'd10 : 4'd0)) begin n_fail++; $display("FAIL st_small10: got %0d want %0d", s_frame_count, STATS ? 10 : 0); end
    // Clear lands on the edge that loads the 11th output frame.
    put(16'h0000, code_at(0, 2'd1), 1'b1);
    clr_stats = 1'b1;
    @(posedge clk); #1;
    clr_stats = 1'b0;
    n_chk++; if (flip_count !== (STATS ? 32'd1 : 32'd0)) begin n_fail++; $display("FAIL st_clr_flips: got %0d want %0d", flip_count, STATS ? 1 : 0); end
    n_chk++; if (frame_count !== (STATS ? 32'd1 : 32'd0)) begin n_fail++; $display("FAIL st_clr_frames: got %0d want %0d", frame_count, STATS ? 1 : 0); end
    n_chk++; if (s_flip_count !== (STATS ? 4'd1 : 4'd0)) begin n_fail++; $display("FAIL st_clr_small: got %0d want %0d", s_flip_count, STATS ? 1 : 0); end
    for (int k = 0; k < 16; k++) put(16'h0000, code_at(0, 2'd1), 1'b1);
    @(posedge clk); #1;
    n_chk++; if (flip_count !== (STATS ? 32'd17 : 32'd0)) begin n_fail++; $display("FAIL st_flips17: got %0d want %0d", flip_count, STATS ? 17 : 0); end
    n_chk++; if (frame_count !== (STATS ? 32'd17 : 32'd0)) begin n_fail++; $display("FAIL st_frames17: got %0d want %0d", frame_count, STATS ? 17 : 0); end
    n_chk++; if (s_flip_count !== (STATS ? 4'd15 : 4'd0)) begin n_fail++; $display("FAIL st_sat_flips: got %0d want %0d", s_flip_count, STATS ? 15 : 0); end
    n_chk++; if (s_frame_count !== (STATS ? 4'd15 : 4'd0)) begin n_fail++; $display("FAIL st_sat_frames: got %0d want %0d", s_frame_count, STATS ? 15 : 0); end
    clr_stats = 1'b1;
    @(posedge clk); #1;
    clr_stats = 1'b0;
    n_chk++; if (flip_count !== 32'd0) begin n_fail++; $display("FAIL st_idle_clr: got %0d want 0", flip_count); end
    n_chk++; if (s_frame_count !== 4'd0) begin n_fail++; $display("FAIL st_idle_clr_small: got %0d want 0", s_frame_count); end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_decode();
    test_back_to_back();
    test_spill();
    test_en0();
    test_reset_mid();
    test_stats();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
